// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream/downstream valid-ready, pipeline
// controls (flush, freeze) and status/performance outputs.
interface pipe_skid_reg_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             flush;
  logic             freeze;
  logic [1:0]       occupancy;
  logic [15:0]      stall_cnt;
  logic [15:0]      flush_cnt;

  // Environment side: produces payload, consumes head, drives pipeline controls.
  modport master (
    output in_valid, in_data, out_ready, flush, freeze,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt, flush_cnt
  );

  // Register side.
  modport slave (
    input  in_valid, in_data, out_ready, flush, freeze,
    output in_ready, out_valid, out_data, occupancy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for the fetch pipeline with flush/freeze control.
// Optional performance counters are built when PIPE_SKID_PERF_EN is defined.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(64'h0000_0000_E000_0000)
) (
  input logic             clk,
  input logic             rst,
  pipe_skid_reg_if.slave  bus
);

  // Encoding equals occupancy so the count is read straight from the state.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // No path from out_ready; rst gates it so nothing is offered during reset.
  assign in_ready  = !rst && (state_q != StTwo) && !bus.freeze;
  assign out_valid = (state_q != StEmpty);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready && !bus.freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      head_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (!bus.freeze) begin
      if (bus.flush) begin
        state_d = StEmpty;
      end else begin
        case (state_q)
          StEmpty: begin
            if (push) begin
              head_d  = bus.in_data;
              state_d = StOne;
            end
          end
          StOne: begin
            if (push && pop) begin
              head_d = bus.in_data;
            end else if (push) begin
              skid_d  = bus.in_data;
              state_d = StTwo;
            end else if (pop) begin
              state_d = StEmpty;
            end
          end
          StTwo: begin
            if (pop) begin
              head_d  = skid_q;
              state_d = StOne;
            end
          end
          default: state_d = StEmpty;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? head_q : BUBBLE;
  assign bus.occupancy = state_q;

`ifdef PIPE_SKID_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if ((bus.freeze || (out_valid && !bus.out_ready)) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (bus.flush && !bus.freeze && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = 16'h0000;
  assign bus.flush_cnt = 16'h0000;
`endif

endmodule
